// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: oversampled start-edge lock, mid-bit sampling,
// registered byte output with one-cycle valid and framing-error strobes.
module uart_rx #(
    parameter int DATA_WIDTH   = 8,
    parameter int BAUDRATE     = 9600,
    parameter int CLK_FREQ_MHZ = 125,
    parameter int OVERSAMPLE   = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  rx_busy
);

    localparam int BAUD_DIV = CLK_FREQ_MHZ * 1_000_000 / (BAUDRATE * OVERSAMPLE);
    localparam int DIV_W    = $clog2(BAUD_DIV) + 1;
    localparam int SMP_W    = $clog2(OVERSAMPLE);
    localparam int BIT_W    = $clog2(DATA_WIDTH) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
    localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    rx_meta_r;
    logic                    rx_s;
    logic                    rx_prev_r;
    logic [DIV_W-1:0]        div_cnt_r;
    logic [DIV_W-1:0]        div_cnt_next_s;
    logic [SMP_W-1:0]        smp_cnt_r;
    logic [SMP_W-1:0]        smp_cnt_next_s;
    logic [BIT_W-1:0]        bit_cnt_r;
    logic [BIT_W-1:0]        bit_cnt_next_s;
    logic [DATA_WIDTH-1:0]   shreg_r;
    logic [DATA_WIDTH-1:0]   shreg_next_s;
    logic [DATA_WIDTH-1:0]   data_next_s;
    logic                    valid_next_s;
    logic                    ferr_next_s;
    logic                    tick_s;
    logic                    smp_last_s;

    assign tick_s     = (div_cnt_r == DIV_LAST);
    assign smp_last_s = (smp_cnt_r == SMP_LAST);

    // Two-flop synchroniser plus one history flop for falling-edge detection; idle line is high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s      <= rx_meta_r;
            rx_prev_r <= rx_s;
        end
    end

    // Next-state, counter and output-strobe logic
    always_comb begin
        state_next_s   = state_r;
        div_cnt_next_s = tick_s ? '0 : div_cnt_r + 1'b1;
        smp_cnt_next_s = smp_cnt_r;
        bit_cnt_next_s = bit_cnt_r;
        shreg_next_s   = shreg_r;
        data_next_s    = data_o;
        valid_next_s   = 1'b0;
        ferr_next_s    = 1'b0;

        if (tick_s) begin
            smp_cnt_next_s = smp_last_s ? '0 : smp_cnt_r + 1'b1;
        end else begin
            smp_cnt_next_s = smp_cnt_r;
        end

        case (state_r)
            IDLE: begin
                // Counters restart on the edge so sampling is phase-locked to it
                div_cnt_next_s = '0;
                smp_cnt_next_s = '0;
                if (rx_prev_r && !rx_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (tick_s && (smp_cnt_r == SMP_MID)) begin
                    if (rx_s) begin
                        state_next_s = IDLE;
                    end else begin
                        smp_cnt_next_s = '0;
                        bit_cnt_next_s = '0;
                        state_next_s   = DATA;
                    end
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (tick_s && smp_last_s) begin
                    shreg_next_s   = {rx_s, shreg_r[DATA_WIDTH-1:1]};
                    bit_cnt_next_s = bit_cnt_r + 1'b1;
                    if (bit_cnt_r == BIT_LAST) begin
                        state_next_s = STOP;
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a zero-gap following start edge is still caught
                if (tick_s && smp_last_s) begin
                    if (rx_s) begin
                        data_next_s  = shreg_r;
                        valid_next_s = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        ferr_next_s  = 1'b1;
                        state_next_s = WAIT_IDLE;
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            WAIT_IDLE: begin
                div_cnt_next_s = '0;
                smp_cnt_next_s = '0;
                if (rx_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_IDLE;
                end
            end
            default: begin
                state_next_s   = IDLE;
                div_cnt_next_s = '0;
                smp_cnt_next_s = '0;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            div_cnt_r <= '0;
            smp_cnt_r <= '0;
            bit_cnt_r <= '0;
            shreg_r   <= '0;
            data_o    <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            div_cnt_r <= div_cnt_next_s;
            smp_cnt_r <= smp_cnt_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            shreg_r   <= shreg_next_s;
            data_o    <= data_next_s;
            rx_valid  <= valid_next_s;
            frame_err <= ferr_next_s;
            rx_busy   <= (state_next_s != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames checked against a
// byte-level model of what a correct 8-N-1 receiver must deliver.
module tb_uart_rx;

    localparam int BIT_CLKS = 16;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rx   = 1'b1;
    logic [7:0] data_o;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    uart_rx #(
        .DATA_WIDTH  (8),
        .BAUDRATE    (62500),
        .CLK_FREQ_MHZ(1),
        .OVERSAMPLE  (16)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (rx),
        .data_o   (data_o),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         ferr_cnt = 0;
    int         busy_cnt = 0;
    int         rd_idx   = 0;
    logic [7:0] got_q[$];
    int         got_t[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(data_o);
            got_t.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
        if (rx_busy) busy_cnt++;
        if (rx_valid || frame_err)
            check_eq("strobe_excl", {31'd0, rx_valid & frame_err}, 32'd0);
    end

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic expect_next(input string tag, input logic [7:0] exp);
        check_eq({tag, "_present"}, {31'd0, got_q.size() > rd_idx}, 32'd1);
        if (got_q.size() > rd_idx) begin
            check_eq(tag, {24'd0, got_q[rd_idx]}, {24'd0, exp});
            rd_idx++;
        end
    endtask

    initial begin : main
        int         f0;
        int         b0;
        int         n0;
        int         exp_ferr;
        logic [7:0] model_q[$];
        logic [7:0] last_good;
        logic [7:0] d;
        logic       bad;

        #2;
        check_eq("rst_data", {24'd0, data_o}, 32'd0);
        check_eq("rst_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
        check_eq("rst_busy", {31'd0, rx_busy}, 32'd0);
        #21 rstn = 1'b1;
        @(posedge clk);
        #1;
        wait_clks(20);

        // Single frame
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b1);
        wait_clks(20);
        expect_next("single_55", 8'h55);
        check_eq("single_ferr", ferr_cnt - f0, 32'd0);
        check_eq("single_busy", {31'd0, rx_busy}, 32'd0);
        check_eq("single_data_hold", {24'd0, data_o}, 32'h55);

        // Back-to-back, no idle gap
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        wait_clks(20);
        n0 = rd_idx;
        expect_next("b2b_A3", 8'hA3);
        expect_next("b2b_0F", 8'h0F);
        if (got_t.size() >= n0 + 2)
            check_eq("b2b_spacing", got_t[n0+1] - got_t[n0], 32'd160);
        else
            check_eq("b2b_spacing_missing", got_t.size(), n0 + 2);

        // Glitch: short low pulse must not start a frame
        f0 = ferr_cnt;
        b0 = busy_cnt;
        n0 = got_q.size();
        rx = 1'b0;
        wait_clks(4);
        rx = 1'b1;
        wait_clks(40);
        check_eq("glitch_ferr", ferr_cnt - f0, 32'd0);
        check_eq("glitch_valid", got_q.size() - n0, 32'd0);
        check_eq("glitch_busy_seen", {31'd0, (busy_cnt - b0) >= 1}, 32'd1);
        check_eq("glitch_busy_le10", {31'd0, (busy_cnt - b0) <= 10}, 32'd1);
        check_eq("glitch_idle", {31'd0, rx_busy}, 32'd0);

        // Framing error, line held low afterwards
        f0 = ferr_cnt;
        n0 = got_q.size();
        send_frame(8'hC6, 1'b0);
        rx = 1'b0;
        wait_clks(40);
        check_eq("ferr_pulse", ferr_cnt - f0, 32'd1);
        check_eq("ferr_no_valid", got_q.size() - n0, 32'd0);
        check_eq("ferr_data_kept", {24'd0, data_o}, 32'h0F);
        check_eq("ferr_busy_low_line", {31'd0, rx_busy}, 32'd1);
        rx = 1'b1;
        wait_clks(32);
        check_eq("ferr_released", {31'd0, rx_busy}, 32'd0);
        check_eq("ferr_no_new", got_q.size() - n0, 32'd0);
        send_frame(8'h3C, 1'b1);
        wait_clks(20);
        expect_next("after_ferr_3C", 8'h3C);

        // Reset in the middle of bit 4
        f0 = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        rx = 1'b1;
        wait_clks(8);
        #2 rstn = 1'b0;
        #1;
        check_eq("midrst_data", {24'd0, data_o}, 32'd0);
        check_eq("midrst_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("midrst_ferr", {31'd0, frame_err}, 32'd0);
        check_eq("midrst_busy", {31'd0, rx_busy}, 32'd0);
        n0 = got_q.size();
        #20 rstn = 1'b1;
        @(posedge clk);
        #1;
        wait_clks(48);
        check_eq("midrst_no_strobe", got_q.size() - n0 + ferr_cnt - f0, 32'd0);
        send_frame(8'h81, 1'b1);
        wait_clks(20);
        expect_next("after_rst_81", 8'h81);

        // Loopback stream from a behavioural transmitter
        f0 = ferr_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h5A, 1'b1);
        wait_clks(20);
        expect_next("loop_00", 8'h00);
        expect_next("loop_FF", 8'hFF);
        expect_next("loop_5A", 8'h5A);
        check_eq("loop_ferr", ferr_cnt - f0, 32'd0);

        // Random frames: model keeps the bytes a correct receiver must deliver
        f0        = ferr_cnt;
        exp_ferr  = 0;
        last_good = 8'h5A;
        for (int k = 0; k < 40; k++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 9) == 0);
            send_frame(d, ~bad);
            if (bad) begin
                exp_ferr++;
                rx = 1'b0;
                wait_clks($urandom_range(0, 20));
                rx = 1'b1;
                wait_clks(BIT_CLKS + $urandom_range(0, 16));
            end else begin
                model_q.push_back(d);
                last_good = d;
                rx = 1'b1;
                if ($urandom_range(0, 2) != 0) wait_clks($urandom_range(1, 40));
            end
        end
        rx = 1'b1;
        wait_clks(40);
        foreach (model_q[i]) expect_next("rand_byte", model_q[i]);
        check_eq("rand_extra", got_q.size(), rd_idx);
        check_eq("rand_ferr", ferr_cnt - f0, exp_ferr);
        check_eq("rand_last_data", {24'd0, data_o}, {24'd0, last_good});
        check_eq("rand_idle", {31'd0, rx_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
